// File: rtl/ps2ser_pkg.sv
// rtl/ps2ser_pkg.sv - shared constants, FSM state type and frame helpers for ps2_key_serializer
package ps2ser_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    GAP,
    INHIBIT
  } ps2ser_state_t;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Bit 0 is sent first: start, data LSB-first, parity, stop.
  function automatic logic [10:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ps2_odd_parity(b), b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - byte FIFO accepting 0-3 bytes per cycle with a single pop
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [1:0]               wr_cnt,
  input  logic [7:0]               wr_data0,
  input  logic [7:0]               wr_data1,
  input  logic [7:0]               wr_data2,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   free,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [AW-1:0] wa0, wa1, wa2;

  always_comb begin
    count   = wptr_q - rptr_q;
    free    = FW'(DEPTH) - count;
    empty   = (count == '0);
    rd_data = mem_q[rptr_q[AW-1:0]];
    wa0     = wptr_q[AW-1:0];
    wa1     = wa0 + 1'b1;
    wa2     = wa0 + 2'd2;
    wptr_d  = wptr_q + {{(AW-1){1'b0}}, wr_cnt};
    rptr_d  = rptr_q + {{AW{1'b0}}, (rd_en && !empty)};
  end

  always_ff @(posedge clk_sys) begin
    if (wr_cnt != 2'd0) mem_q[wa0] <= wr_data0;
    if (wr_cnt >= 2'd2) mem_q[wa1] <= wr_data1;
    if (wr_cnt == 2'd3) mem_q[wa2] <= wr_data2;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/ps2_key_serializer.sv
// rtl/ps2_key_serializer.sv - hps_io ps2_key events to PS/2 device-to-host frames
// Optional host clock inhibit/resend when PS2SER_INHIBIT_EN is defined.
module ps2_key_serializer
  import ps2ser_pkg::*;
#(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_HALVES  = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
`ifdef PS2SER_INHIBIT_EN
  ,
  input  logic        ps2_clk_in
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int FW      = AW + 1;
  localparam int GAP_CYC = GAP_HALVES * HALF_PERIOD;
  localparam int CNT_MAX = (GAP_CYC > 2 * HALF_PERIOD) ? GAP_CYC : 2 * HALF_PERIOD;
  localparam int CW      = $clog2(CNT_MAX);

  logic          key_prev_q, key_prev_d, armed_q, armed_d;
  logic          ev, ext, brk;
  logic [1:0]    nbytes, wr_cnt;
  logic [7:0]    wb0, wb1, wb2;
  logic [AW:0]   fifo_free;
  logic          fifo_empty, pop;
  logic [7:0]    fifo_rd;

  ps2ser_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d, idx_inc;
  logic [10:0]   shreg_q, shreg_d;
  logic          ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d;
  logic          busy_q, busy_d, overflow_q, overflow_d, done;

`ifdef PS2SER_INHIBIT_EN
  logic [1:0] inh_sync_q, inh_sync_d;
  logic       host_clk_hi;

  assign inh_sync_d  = {inh_sync_q[0], ps2_clk_in};
  assign host_clk_hi = inh_sync_q[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) inh_sync_q <= 2'b11;
    else          inh_sync_q <= inh_sync_d;
  end
`endif

  // Event expansion: bytes land in the FIFO all together or not at all.
  always_comb begin
    key_prev_d = ps2_key[10];
    armed_d    = 1'b1;
    ev         = armed_q && (ps2_key[10] != key_prev_q);
    ext        = ps2_key[8];
    brk        = ~ps2_key[9];
    nbytes     = 2'd1 + {1'b0, ext} + {1'b0, brk};
    wb0        = ps2_key[7:0];
    wb1        = ps2_key[7:0];
    wb2        = ps2_key[7:0];
    case ({ext, brk})
      2'b10:   wb0 = PS2_EXT_PREFIX;
      2'b01:   wb0 = PS2_BREAK_PREFIX;
      2'b11: begin
        wb0 = PS2_EXT_PREFIX;
        wb1 = PS2_BREAK_PREFIX;
      end
      default: ;
    endcase
    overflow_d = ev && (fifo_free < FW'(nbytes));
    wr_cnt     = (ev && !overflow_d) ? nbytes : 2'd0;
  end

  ps2_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr_cnt  (wr_cnt),
    .wr_data0(wb0),
    .wr_data1(wb1),
    .wr_data2(wb2),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .free    (fifo_free),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    pop        = 1'b0;
    idx_inc    = idx_q + 4'd1;
    done       = 1'b0;

    case (state_q)
      GAP:     done = (cnt_q == CW'(GAP_CYC - 1));
      INHIBIT: done = (cnt_q == CW'(2 * HALF_PERIOD - 1));
      default: done = (cnt_q == CW'(HALF_PERIOD - 1));
    endcase

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = ps2_frame(fifo_rd);
          idx_d      = 4'd0;
          state_d    = HI;
          ps2_clk_d  = 1'b1;
          ps2_data_d = shreg_d[0];
        end
      end
      HI: begin
`ifdef PS2SER_INHIBIT_EN
        if (!host_clk_hi && idx_q != 4'd10) begin
          state_d    = INHIBIT;
          cnt_d      = '0;
          ps2_data_d = 1'b1;
        end else
`endif
        if (done) begin
          state_d   = LO;
          cnt_d     = '0;
          ps2_clk_d = 1'b0;
        end
      end
      LO: begin
        if (done) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          if (idx_q == 4'd10) begin
            state_d    = GAP;
            ps2_data_d = 1'b1;
          end else begin
            // Data only moves here, while the clock is going back high.
            idx_d      = idx_inc;
            state_d    = HI;
            ps2_data_d = shreg_q[idx_inc];
          end
        end
      end
      GAP: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`ifdef PS2SER_INHIBIT_EN
      INHIBIT: begin
        if (!host_clk_hi) begin
          cnt_d = '0;
        end else if (done) begin
          state_d    = HI;
          cnt_d      = '0;
          idx_d      = 4'd0;
          ps2_data_d = shreg_q[0];
        end
      end
`endif
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE) || !fifo_empty || (wr_cnt != 2'd0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_serializer.sv
// tb/tb_ps2_key_serializer.sv - scoreboard bench for ps2_key_serializer; inhibit case under PS2SER_INHIBIT_EN
module tb_ps2_key_serializer;

  localparam int HP = 4;
  localparam int GH = 4;
  localparam int FD = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        ps2_clk, ps2_data, busy, overflow;
  logic        ps2_clk_in = 1'b1;

  int          total = 0;
  int          bad   = 0;
  logic [10:0] sb[$];

  always #5 clk_sys = ~clk_sys;

  ps2_key_serializer #(
    .HALF_PERIOD(HP),
    .GAP_HALVES (GH),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy),
    .overflow(overflow)
`ifdef PS2SER_INHIBIT_EN
    ,
    .ps2_clk_in(ps2_clk_in)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Monitor: decode bits on ps2_clk falling edges and compare against the scoreboard.
  int          nbits  = 0;
  int          hi_run = 0;
  logic [10:0] rx     = '0;
  logic        prev_clk = 1'b1, prev_data = 1'b1, glitch = 1'b0;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      nbits  = 0;
      hi_run = 0;
      glitch = 1'b0;
    end else begin
      if (!ps2_clk && !prev_clk && ps2_data !== prev_data) glitch = 1'b1;
      if (prev_clk && !ps2_clk) begin
        rx[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          if (sb.size() == 0) begin
            check("frame_unexpected", int'(rx), -1);
          end else begin
            check("frame", int'(rx), int'(sb.pop_front()));
          end
          check("data_stable_while_clk_low", int'(glitch), 0);
          nbits  = 0;
          glitch = 1'b0;
        end
      end
      hi_run = ps2_clk ? hi_run + 1 : 0;
      if (hi_run > 2 * HP + 2 && nbits != 0) begin
        nbits  = 0;
        glitch = 1'b0;
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic run_until_idle(input int limit, output int nbusy, output int nlow,
                                output int first0, output int novf);
    nbusy  = 0;
    nlow   = 0;
    novf   = 0;
    first0 = -1;
    @(negedge clk_sys);
    while (busy && nbusy < limit) begin
      if (!ps2_data && first0 < 0) first0 = nbusy;
      if (!ps2_clk) nlow++;
      if (overflow) novf++;
      nbusy++;
      @(negedge clk_sys);
    end
    check("idle_within_budget", int'(nbusy < limit), 1);
  endtask

  task automatic send_key(input logic press, input logic ext, input logic [7:0] code);
    @(posedge clk_sys);
    #1 ps2_key = {~ps2_key[10], press, ext, code};
  endtask

  int nb, nl, f0, nov, act;

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("reset_ps2_clk", int'(ps2_clk), 1);
    check("reset_ps2_data", int'(ps2_data), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(overflow), 0);
    repeat (3) @(posedge clk_sys);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);

    // Make code 1C: 3 ones -> parity 0.
    sb.push_back(frame(8'h1C, 1'b0));
    send_key(1'b1, 1'b0, 8'h1C);
    @(negedge clk_sys);
    check("make_busy_in_event_cycle", int'(busy), 0);
    run_until_idle(2000, nb, nl, f0, nov);
    check("make_busy_cycles", nb, 105);
    check("make_clk_low_cycles", nl, 44);
    check("make_start_bit_latency", f0, 1);
    check("make_idle_clk", int'(ps2_clk), 1);
    check("make_idle_data", int'(ps2_data), 1);

    // Extended break of 75: E0 (p0), F0 (p1), 75 (p0).
    sb.push_back(frame(8'hE0, 1'b0));
    sb.push_back(frame(8'hF0, 1'b1));
    sb.push_back(frame(8'h75, 1'b0));
    send_key(1'b0, 1'b1, 8'h75);
    @(negedge clk_sys);
    run_until_idle(2000, nb, nl, f0, nov);
    check("extbrk_busy_cycles", nb, 315);
    check("extbrk_clk_low_cycles", nl, 132);

    // Four 3-byte events 2 cycles apart: the 4th cannot fit.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        sb.push_back(frame(8'hE0, 1'b0));
        sb.push_back(frame(8'hF0, 1'b1));
        sb.push_back(frame(8'h75, 1'b0));
      end
      send_key(1'b0, 1'b1, 8'h75);
      @(posedge clk_sys);
    end
    run_until_idle(5000, nb, nl, f0, nov);
    check("overflow_pulse_cycles", nov, 1);
    check("overflow_busy_cycles", nb, 939);

`ifdef PS2SER_INHIBIT_EN
    // 33 has 4 ones -> parity 1. Host pulls clock low during bit 3 HI.
    sb.push_back(frame(8'h33, 1'b1));
    send_key(1'b1, 1'b0, 8'h33);
    repeat (25) @(posedge clk_sys);
    #1 ps2_clk_in = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    check("inhibit_clk_released", int'(ps2_clk), 1);
    check("inhibit_data_released", int'(ps2_data), 1);
    repeat (14) @(posedge clk_sys);
    #1 ps2_clk_in = 1'b1;
    run_until_idle(2000, nb, nl, f0, nov);
    check("inhibit_resend_clk_low", nl, 44);
`endif

    // Reset during bit 5: frame discarded, lines released asynchronously.
    sb.push_back(frame(8'h2A, 1'b0));
    send_key(1'b1, 1'b0, 8'h2A);
    repeat (44) @(posedge clk_sys);
    #3;
    check("midframe_busy_before_reset", int'(busy), 1);
    check("midframe_bits_before_reset", nbits, 5);
    reset_n = 1'b0;
    #1;
    check("midframe_reset_clk", int'(ps2_clk), 1);
    check("midframe_reset_data", int'(ps2_data), 1);
    check("midframe_reset_busy", int'(busy), 0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk_sys);
    #2 reset_n = 1'b1;

    // Static key after reset release and for the idle stretch: nothing happens.
    act = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys);
      if (busy || !ps2_clk || !ps2_data || overflow) act++;
    end
    check("static_key_activity_cycles", act, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
